// File: rtl/tiny_soc_pkg.sv
// Shared types and MMIO register map for the tiny-SoC memory/MMIO responder.
package tiny_soc_pkg;

    localparam logic [7:0] MmioStopOff  = 8'h00;
    localparam logic [7:0] MmioPrintOff = 8'h08;
    localparam logic [7:0] MmioCycleOff = 8'h10;

    typedef logic [63:0] data_t;
    typedef logic [7:0]  strb_t;

    typedef enum logic {
        MMIO_IDLE = 1'b0,
        MMIO_RESP = 1'b1
    } mmio_state_e;

endpackage

// File: rtl/tiny_soc_mmio_regs.sv
// MMIO register file: stop, print and free-running cycle counter behind a
// two-state accept/respond FSM (one access every two cycles at most).
module tiny_soc_mmio_regs
    import tiny_soc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [7:0]  off_i,
    input  logic        strb0_i,
    input  data_t       wdata_i,
    output logic        gnt_o,
    output data_t       rdata_o,
    output logic        stop_o,
    output logic        print_valid_o,
    output logic [7:0]  print_char_o,
    output logic        err_o,
    output mmio_state_e state_o
);

    mmio_state_e state_q;
    data_t       rdata_q;
    data_t       cycle_q;
    logic        stop_q;
    logic        print_valid_q;
    logic [7:0]  print_char_q;
    logic        err_q;

    assign gnt_o = req_i && (state_q == MMIO_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= MMIO_IDLE;
            rdata_q       <= '0;
            cycle_q       <= '0;
            stop_q        <= 1'b0;
            print_valid_q <= 1'b0;
            print_char_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            cycle_q       <= cycle_q + 64'd1;
            print_valid_q <= 1'b0;
            rdata_q       <= '0;
            case (state_q)
                MMIO_IDLE: begin
                    if (req_i) begin
                        state_q <= MMIO_RESP;
                        // Read data is latched here so it is stable for the whole RESP cycle.
                        case (off_i)
                            MmioStopOff: begin
                                if (we_i) begin
                                    if (wdata_i != '0) stop_q <= 1'b1;
                                end else begin
                                    rdata_q <= {63'b0, stop_q};
                                end
                            end
                            MmioPrintOff: begin
                                if (we_i && strb0_i) begin
                                    print_valid_q <= 1'b1;
                                    print_char_q  <= wdata_i[7:0];
                                end
                            end
                            MmioCycleOff: begin
                                if (!we_i) rdata_q <= cycle_q;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                MMIO_RESP: state_q <= MMIO_IDLE;
            endcase
        end
    end

    assign rdata_o       = rdata_q;
    assign stop_o        = stop_q;
    assign print_valid_o = print_valid_q;
    assign print_char_o  = print_char_q;
    assign err_o         = err_q;
    assign state_o       = state_q;

endmodule

// File: rtl/tiny_soc_mem_responder.sv
// Sink for core memory and MMIO traffic: byte-strobed word SRAM with a fixed
// response latency, plus the MMIO register block.
module tiny_soc_mem_responder
    import tiny_soc_pkg::*;
#(
    parameter int unsigned NumWords      = 1 << 20,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned MMIOAddrWidth = 31,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned RespLatency   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     mem_req_i,
    output logic                     mem_gnt_o,
    input  logic                     mem_we_i,
    input  logic [AddrWidth-1:0]     mem_addr_i,
    input  logic [DataWidth/8-1:0]   mem_strb_i,
    input  logic [DataWidth-1:0]     mem_wdata_i,
    output logic                     mem_rvalid_o,
    output logic [DataWidth-1:0]     mem_rdata_o,
    input  logic                     mmio_req_i,
    output logic                     mmio_gnt_o,
    input  logic                     mmio_we_i,
    input  logic [MMIOAddrWidth-1:0] mmio_addr_i,
    input  logic [DataWidth/8-1:0]   mmio_strb_i,
    input  logic [DataWidth-1:0]     mmio_wdata_i,
    output logic                     mmio_rvalid_o,
    output logic [DataWidth-1:0]     mmio_rdata_o,
    output logic                     stop_o,
    output logic                     print_valid_o,
    output logic [7:0]               print_char_o,
    output logic                     mmio_err_o
);

    localparam int unsigned IdxW = $clog2(NumWords);

    // Handshake on both ports: a request is accepted in every cycle where req
    // and gnt are both high; each accepted request (read or write) yields exactly
    // one rvalid pulse, in request order, with no back-pressure on responses.

    data_t                  mem_q [NumWords];
    logic [RespLatency-1:0] pipe_vld_q;
    data_t                  pipe_data_q [RespLatency];
    logic [IdxW-1:0]        idx;
    mmio_state_e            mmio_state;
    logic                   unused_bits;

    assign idx       = mem_addr_i[3 +: IdxW];
    assign mem_gnt_o = mem_req_i;

    // SRAM contents survive reset; only the response pipeline is cleared.
    always_ff @(posedge clk_i) begin
        if (mem_req_i && mem_we_i) begin
            for (int b = 0; b < 8; b++) begin
                if (mem_strb_i[b]) mem_q[idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RespLatency; i++) pipe_data_q[i] <= '0;
        end else begin
            pipe_vld_q[0]  <= mem_req_i;
            pipe_data_q[0] <= (mem_req_i && !mem_we_i) ? mem_q[idx] : '0;
            for (int i = 1; i < RespLatency; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_data_q[i] <= pipe_data_q[i-1];
            end
        end
    end

    assign mem_rvalid_o = pipe_vld_q[RespLatency-1];
    assign mem_rdata_o  = pipe_data_q[RespLatency-1];

    tiny_soc_mmio_regs u_mmio_regs (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (mmio_req_i),
        .we_i          (mmio_we_i),
        .off_i         (mmio_addr_i[7:0]),
        .strb0_i       (mmio_strb_i[0]),
        .wdata_i       (mmio_wdata_i),
        .gnt_o         (mmio_gnt_o),
        .rdata_o       (mmio_rdata_o),
        .stop_o        (stop_o),
        .print_valid_o (print_valid_o),
        .print_char_o  (print_char_o),
        .err_o         (mmio_err_o),
        .state_o       (mmio_state)
    );

    assign mmio_rvalid_o = (mmio_state == MMIO_RESP);

    assign unused_bits = ^{mem_addr_i[2:0], mem_addr_i[AddrWidth-1:IdxW+3],
                           mmio_addr_i[MMIOAddrWidth-1:8], mmio_strb_i[7:1]};

endmodule
